// File: rtl/pci_mem_pkg.sv
// pci_mem_pkg: shared commands, FSM states and byte-enable helper for pci_target_mem
package pci_mem_pkg;
   localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
   localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;
   localparam int MAX_DW = 1024;
   localparam int MAX_BE = MAX_DW / 8;
   typedef enum logic [2:0] {ST_IDLE, ST_ABORT, ST_WAIT, ST_FETCH, ST_WDATA, ST_RDATA} state_t;
   // Sized for the widest supported bus; callers cast the result down to DATA_W.
   function automatic logic [MAX_DW-1:0] be_to_mask(input logic [MAX_BE-1:0] be);
      logic [MAX_DW-1:0] m;
      for (int i = 0; i < MAX_BE; i++) m[i*8 +: 8] = {8{be[i]}};
      return m;
   endfunction
endpackage

// File: rtl/mem_be_array.sv
// mem_be_array: single-port synchronous word array with byte enables and a registered read
module mem_be_array
   import pci_mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   localparam int BE_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic              re,
   input  logic [BE_W-1:0]   be,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q, rdata_d, mask;
   always_comb begin
      mask = DATA_W'(be_to_mask(MAX_BE'(be)));
      rdata_d = re ? mem[addr] : rdata_q;
   end
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
   end
   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else rdata_q <= rdata_d;
   end
   assign rdata = rdata_q;
endmodule

// File: rtl/pci_target_mem.sv
// pci_target_mem: burst memory target with wait states, byte enables and command abort
module pci_target_mem
   import pci_mem_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 16,
   parameter int WAIT_STATES = 0,
   localparam int BE_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_cmd,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              dph_valid,
   output logic              dph_ready,
   input  logic              dph_last,
   input  logic [BE_W-1:0]   dph_be,
   input  logic [DATA_W-1:0] dph_wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              err
);
   state_t state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, addr_inc, mem_addr;
   logic [3:0] cmd_q, cmd_d;
   logic [2:0] wcnt_q, wcnt_d;
   logic is_rd, req_rd, req_ok, xfer, mem_we, mem_re;
   state_t data_st;
   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      cmd_d = cmd_q;
      wcnt_d = wcnt_q;
      addr_inc = addr_q + ADDR_W'(1);
      is_rd = cmd_q == CMD_MEM_READ;
      req_rd = req_cmd == CMD_MEM_READ;
      req_ok = req_rd || req_cmd == CMD_MEM_WRITE;
      data_st = is_rd ? ST_FETCH : ST_WDATA;
      req_ready = state_q == ST_IDLE;
      busy = !req_ready;
      err = state_q == ST_ABORT;
      dph_ready = state_q == ST_WDATA || state_q == ST_RDATA;
      xfer = dph_ready && dph_valid;
      mem_we = state_q == ST_WDATA && xfer && !rst;
      mem_re = state_q == ST_FETCH || (state_q == ST_RDATA && xfer);
      // Read beats prefetch the next word so the following beat has no bubble.
      mem_addr = state_q == ST_RDATA ? addr_inc : addr_q;
      unique case (state_q)
         ST_IDLE: if (req_valid) begin
            cmd_d = req_cmd;
            addr_d = req_addr;
            wcnt_d = WAIT_STATES > 0 ? 3'(WAIT_STATES - 1) : 3'd0;
            state_d = !req_ok ? ST_ABORT : WAIT_STATES > 0 ? ST_WAIT : req_rd ? ST_FETCH : ST_WDATA;
         end
         ST_ABORT: state_d = ST_IDLE;
         ST_WAIT: begin
            wcnt_d = wcnt_q == 3'd0 ? 3'd0 : wcnt_q - 3'd1;
            state_d = wcnt_q == 3'd0 ? data_st : ST_WAIT;
         end
         ST_FETCH: state_d = ST_RDATA;
         ST_WDATA, ST_RDATA: if (xfer) begin
            addr_d = addr_inc;
            state_d = dph_last ? ST_IDLE : state_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q <= '0;
         cmd_q <= '0;
         wcnt_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         cmd_q <= cmd_d;
         wcnt_q <= wcnt_d;
      end
   end
   mem_be_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
      .clk(clk),
      .rst(rst),
      .addr(mem_addr),
      .we(mem_we),
      .re(mem_re),
      .be(dph_be),
      .wdata(dph_wdata),
      .rdata(rdata)
   );
endmodule

// File: tb/tb_pci_target_mem.sv
// tb_pci_target_mem: randomized bench for pci_target_mem at zero and three wait states
module tb_pci_target_mem;
   import pci_mem_pkg::*;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic rv0 = 1'b0, rv3 = 1'b0, dv = 1'b0, dl = 1'b0;
   logic [3:0] cmd = '0, be = '0;
   logic [15:0] addr = '0;
   logic [31:0] wd = '0;
   logic rr0, rr3, dr0, dr3, b0, b3, e0, e3;
   logic [31:0] rd0, rd3;
   int sel = 0;
   logic req_ready, dph_ready, busy, err;
   logic [31:0] rdata;
   assign req_ready = sel != 0 ? rr3 : rr0;
   assign dph_ready = sel != 0 ? dr3 : dr0;
   assign busy = sel != 0 ? b3 : b0;
   assign err = sel != 0 ? e3 : e0;
   assign rdata = sel != 0 ? rd3 : rd0;

   pci_target_mem #(.DATA_W(32), .ADDR_W(16), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0), .req_cmd(cmd), .req_addr(addr),
      .dph_valid(dv), .dph_ready(dr0), .dph_last(dl), .dph_be(be), .dph_wdata(wd),
      .rdata(rd0), .busy(b0), .err(e0));
   pci_target_mem #(.DATA_W(32), .ADDR_W(16), .WAIT_STATES(3)) u_dut3 (
      .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rr3), .req_cmd(cmd), .req_addr(addr),
      .dph_valid(dv), .dph_ready(dr3), .dph_last(dl), .dph_be(be), .dph_wdata(wd),
      .rdata(rd3), .busy(b3), .err(e3));

   int total = 0, bad = 0;
   logic [31:0] ref_mem [int];
   logic [31:0] wq[$];
   logic [3:0] bq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int key(input int s, input logic [15:0] a);
      return s * 65536 + int'(a);
   endfunction

   function automatic int ws(input int s);
      return s != 0 ? 3 : 0;
   endfunction

   task automatic set_rv(input int s, input logic v);
      if (s != 0) rv3 = v;
      else rv0 = v;
   endtask

   task automatic request(input int s, input logic [3:0] c, input logic [15:0] a);
      sel = s;
      check("req_ready_idle", 32'(req_ready), 32'd1);
      cmd = c;
      addr = a;
      set_rv(s, 1'b1);
      tick;
      set_rv(s, 1'b0);
   endtask

   task automatic wait_ready(input string tag, input int exp_lat);
      int lat = 1;
      while (!dph_ready && lat < 20) begin
         tick;
         lat++;
      end
      check(tag, lat, exp_lat);
   endtask

   // Writes the beats queued in wq/bq; rst_beat >= 0 asserts reset on that beat instead.
   task automatic wr_burst(input int s, input logic [15:0] a, input int rst_beat);
      logic [15:0] p = a;
      logic [31:0] w;
      int k;
      request(s, CMD_MEM_WRITE, a);
      wait_ready("wr_latency", ws(s) + 1);
      for (int i = 0; i < wq.size(); i++) begin
         if (rst_beat < 0 && $urandom_range(0, 3) == 0) begin
            dv = 1'b0;
            tick;
            check("wr_stall_ready", 32'(dph_ready), 32'd1);
         end
         dv = 1'b1;
         wd = wq[i];
         be = bq[i];
         dl = i == wq.size() - 1;
         if (i == rst_beat) begin
            rst = 1'b1;
            tick;
            rst = 1'b0;
            dv = 1'b0;
            dl = 1'b0;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_req_ready", 32'(req_ready), 32'd1);
            check("rst_dph_ready", 32'(dph_ready), 32'd0);
            check("rst_rdata", rdata, 32'd0);
            wq.delete();
            bq.delete();
            return;
         end
         tick;
         k = key(s, p);
         w = ref_mem.exists(k) ? ref_mem[k] : 32'd0;
         for (int j = 0; j < 4; j++) if (bq[i][j]) w[j*8 +: 8] = wq[i][j*8 +: 8];
         if (ref_mem.exists(k) || bq[i] == 4'hF) ref_mem[k] = w;
         p++;
      end
      dv = 1'b0;
      dl = 1'b0;
      check("wr_end_idle", 32'(req_ready), 32'd1);
      check("wr_end_busy", 32'(busy), 32'd0);
      wq.delete();
      bq.delete();
   endtask

   task automatic rd_burst(input int s, input logic [15:0] a, input int n, input int stall_at,
                           input int stall_len);
      logic [15:0] p = a;
      logic [31:0] hold;
      request(s, CMD_MEM_READ, a);
      wait_ready("rd_latency", ws(s) + 2);
      for (int i = 0; i < n; i++) begin
         if (i == stall_at) begin
            for (int j = 0; j < stall_len; j++) begin
               dv = 1'b0;
               hold = rdata;
               tick;
               check("rd_stall_hold", rdata, hold);
            end
         end
         check("rd_ready", 32'(dph_ready), 32'd1);
         if (ref_mem.exists(key(s, p))) check("rd_data", rdata, ref_mem[key(s, p)]);
         dv = 1'b1;
         dl = i == n - 1;
         tick;
         p++;
      end
      dv = 1'b0;
      dl = 1'b0;
      check("rd_end_idle", 32'(req_ready), 32'd1);
   endtask

   task automatic bad_cmd(input int s, input logic [15:0] a);
      request(s, 4'b0010, a);
      dv = 1'b1;
      be = 4'hF;
      wd = 32'hDEAD_BEEF;
      check("abort_err", 32'(err), 32'd1);
      check("abort_req_ready", 32'(req_ready), 32'd0);
      tick;
      dv = 1'b0;
      check("abort_err_end", 32'(err), 32'd0);
      check("abort_req_ready_end", 32'(req_ready), 32'd1);
   endtask

   task automatic push(input logic [31:0] d, input logic [3:0] b);
      wq.push_back(d);
      bq.push_back(b);
   endtask

   initial begin
      repeat (3) tick;
      check("reset_rr0", 32'(rr0), 32'd1);
      check("reset_dr0", 32'(dr0), 32'd0);
      check("reset_b0", 32'(b0), 32'd0);
      check("reset_e0", 32'(e0), 32'd0);
      check("reset_rd0", rd0, 32'd0);
      check("reset_rr3", 32'(rr3), 32'd1);
      check("reset_rd3", rd3, 32'd0);
      rst = 1'b0;
      tick;
      for (int i = 1; i <= 4; i++) push(32'h1111_1111 * i, 4'hF);
      wr_burst(0, 16'h0010, -1);
      rd_burst(0, 16'h0010, 4, -1, 0);
      push(32'hAABB_CCDD, 4'hF);
      wr_burst(0, 16'h0020, -1);
      push(32'h1122_3344, 4'b0101);
      wr_burst(0, 16'h0020, -1);
      rd_burst(0, 16'h0020, 1, -1, 0);
      for (int i = 0; i < 3; i++) push($urandom, 4'hF);
      wr_burst(0, 16'hFFFE, -1);
      rd_burst(0, 16'hFFFE, 3, -1, 0);
      rd_burst(0, 16'h0000, 1, -1, 0);
      for (int i = 0; i < 8; i++) push($urandom, 4'hF);
      wr_burst(1, 16'h0040, -1);
      rd_burst(1, 16'h0040, 8, 3, 2);
      bad_cmd(0, 16'h0020);
      rd_burst(0, 16'h0020, 1, -1, 0);
      bad_cmd(1, 16'h0040);
      rd_burst(1, 16'h0040, 2, -1, 0);
      for (int i = 0; i < 4; i++) push(32'h5A5A_0000 + i, 4'hF);
      wr_burst(0, 16'h0030, -1);
      for (int i = 0; i < 4; i++) push(32'hC3C3_0000 + i, 4'hF);
      wr_burst(0, 16'h0030, 1);
      rd_burst(0, 16'h0030, 4, -1, 0);
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 64; i++) push($urandom, 4'hF);
         wr_burst(s, 16'h0100, -1);
      end
      for (int t = 0; t < 40; t++) begin
         int s = int'($urandom_range(0, 1));
         int kind = int'($urandom_range(0, 9));
         int n = int'($urandom_range(1, 8));
         logic [15:0] a = 16'h0100 + 16'($urandom_range(0, 48));
         if (kind < 4) begin
            for (int i = 0; i < n; i++) push($urandom, 4'($urandom_range(0, 15)));
            wr_burst(s, a, -1);
         end else if (kind < 8) begin
            rd_burst(s, a, n, int'($urandom_range(0, n)), int'($urandom_range(0, 2)));
         end else begin
            bad_cmd(s, a);
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
